// File: rtl/fib_bcd.sv
// fib_bcd: sequential 16-bit binary to 5-digit packed BCD converter (shift-add-3).
// Sits downstream of the Fibonacci generator. It accepts a term when idle and
// delivers the result 16 cycles later with a one-cycle done pulse. Terms offered
// while busy are dropped and counted in a saturating counter.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   in_valid_i     term available from the generator
//   in_data_i      16-bit unsigned term, sampled only on the accept edge
//   in_ready_o     converter idle; accept on in_valid_i & in_ready_o
//   bcd_out_o      packed BCD, digit 4 in [19:16] down to digit 0 in [3:0]
//   out_valid_o    one-cycle pulse when bcd_out_o/digit_count_o update
//   digit_count_o  significant digits in bcd_out_o, 1..5
//   busy_o         conversion in progress
//   drop_cnt_o     saturating count of terms offered while not ready
//
// Build option: define FIB_BCD_BLANK_EN to replace leading zero digits above
// digit_count_o with 4'hF in bcd_out_o (digit 0 is never blanked).

module fib_bcd (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        in_valid_i,
   input  logic [15:0] in_data_i,
   output logic        in_ready_o,
   output logic [19:0] bcd_out_o,
   output logic        out_valid_o,
   output logic [2:0]  digit_count_o,
   output logic        busy_o,
   output logic [7:0]  drop_cnt_o
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e      state_q, state_d;
   logic [15:0] shreg_q, shreg_d;
   logic [19:0] scratch_q, scratch_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [19:0] bcd_q, bcd_d;
   logic [2:0]  dcnt_q, dcnt_d;
   logic        out_valid_q, out_valid_d;
   logic [7:0]  drop_q, drop_d;

   logic [19:0] adj;
   logic [35:0] shifted;

   // Index of highest nonzero digit plus one; zero still counts as one digit.
   function automatic logic [2:0] f_count(input logic [19:0] b);
      logic [2:0] n;
      n = 3'd1;
      for (int i = 1; i < 5; i++) begin
         if (b[4*i +: 4] != 4'd0) n = 3'(i + 1);
      end
      return n;
   endfunction

   function automatic logic [19:0] f_present(input logic [19:0] b, input logic [2:0] n);
      logic [19:0] r;
      r = b;
`ifdef FIB_BCD_BLANK_EN
      for (int i = 1; i < 5; i++) begin
         if (3'(i) >= n) r[4*i +: 4] = 4'hF;
      end
`else
      if (n == 3'd0) r = b;
`endif
      return r;
   endfunction

   // Per-digit add-3 correction, no carry between digits.
   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < 5; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
   end

   assign shifted = {adj, shreg_q} << 1;

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      scratch_d   = scratch_q;
      cnt_d       = cnt_q;
      bcd_d       = bcd_q;
      dcnt_d      = dcnt_q;
      out_valid_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               shreg_d   = in_data_i;
               scratch_d = 20'd0;
               cnt_d     = 4'd0;
               state_d   = StShift;
            end
         end
         StShift: begin
            {scratch_d, shreg_d} = shifted;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               dcnt_d      = f_count(shifted[35:16]);
               bcd_d       = f_present(shifted[35:16], f_count(shifted[35:16]));
               out_valid_d = 1'b1;
               state_d     = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      drop_d = drop_q;
      if (in_valid_i && (state_q != StIdle) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         shreg_q     <= 16'd0;
         scratch_q   <= 20'd0;
         cnt_q       <= 4'd0;
         bcd_q       <= 20'd0;
         dcnt_q      <= 3'd1;
         out_valid_q <= 1'b0;
         drop_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         scratch_q   <= scratch_d;
         cnt_q       <= cnt_d;
         bcd_q       <= bcd_d;
         dcnt_q      <= dcnt_d;
         out_valid_q <= out_valid_d;
         drop_q      <= drop_d;
      end
   end

   assign in_ready_o    = (state_q == StIdle);
   assign busy_o        = (state_q != StIdle);
   assign bcd_out_o     = bcd_q;
   assign digit_count_o = dcnt_q;
   assign out_valid_o   = out_valid_q;
   assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_fib_bcd.sv
// tb_fib_bcd: directed plus randomized self-checking bench for fib_bcd.
// Expected BCD values come from decimal arithmetic on the input term.

module tb_fib_bcd;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic [19:0] bcd_out;
   logic        out_valid;
   logic [2:0]  digit_count;
   logic        busy;
   logic [7:0]  drop_cnt;

   int checks = 0;
   int errors = 0;

   fib_bcd dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .in_valid_i    (in_valid),
      .in_data_i     (in_data),
      .in_ready_o    (in_ready),
      .bcd_out_o     (bcd_out),
      .out_valid_o   (out_valid),
      .digit_count_o (digit_count),
      .busy_o        (busy),
      .drop_cnt_o    (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ref_digits(input int v);
      int n;
      int t;
      n = 1;
      t = v;
      while (t >= 10) begin
         t = t / 10;
         n++;
      end
      return n;
   endfunction

   function automatic logic [19:0] ref_bcd(input int v);
      logic [19:0] r;
      int p;
      int n;
      r = 20'd0;
      p = 1;
      n = ref_digits(v);
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
`ifdef FIB_BCD_BLANK_EN
         if (i >= n) r[4*i +: 4] = 4'hF;
`endif
         p = p * 10;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 40) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
   endtask

   // Counts edges until out_valid; the result must appear after exp_n edges.
   task automatic wait_done(input string tag, input int v, input int exp_n);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (out_valid !== 1'b1 && n < 40);
      chk({tag, "_latency"}, 32'(n), 32'(exp_n));
      chk({tag, "_bcd"}, {12'd0, bcd_out}, {12'd0, ref_bcd(v)});
      chk({tag, "_dcnt"}, {29'd0, digit_count}, 32'(ref_digits(v)));
      @(posedge clk);
      #1;
      chk({tag, "_pulse_end"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_ready_again"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic convert(input string tag, input int v);
      wait_ready();
      in_valid = 1'b1;
      in_data  = 16'(v);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      wait_done(tag, v, 16);
   endtask

   initial begin : main
      int v1;
      int v2;
      int model_drop;
      int seen_pulse;
      logic ready_before;

      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_bcd", {12'd0, bcd_out}, 32'd0);
      chk("rst_dcnt", {29'd0, digit_count}, 32'd1);
      chk("rst_drop", {24'd0, drop_cnt}, 32'd0);

      convert("zero", 0);
      convert("max", 65535);
      convert("v987", 987);
      for (int i = 0; i < 8; i++) convert("rand", int'($urandom_range(0, 65535)));

      // Valid held high with changing data: accepts at E0 and E18.
      wait_ready();
      v1       = int'($urandom_range(0, 65535));
      in_valid = 1'b1;
      in_data  = 16'(v1);
      @(posedge clk);
      #1;
      in_data = 16'($urandom);
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk);
         #1;
         if (k == 16) begin
            chk("hold_v1_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_v1_bcd", {12'd0, bcd_out}, {12'd0, ref_bcd(v1)});
         end
         in_data = 16'($urandom);
      end
      chk("hold_drop17", {24'd0, drop_cnt}, 32'd17);
      chk("hold_ready_e17", {31'd0, in_ready}, 32'd1);
      v2 = int'(in_data);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      chk("hold_accept_e18", {31'd0, busy}, 32'd1);
      chk("hold_drop_e18", {24'd0, drop_cnt}, 32'd17);
      wait_done("hold_v2", v2, 16);

      // Long drop run to saturation.
      model_drop = 17;
      in_valid = 1'b1;
      for (int k = 0; k < 300; k++) begin
         in_data      = 16'($urandom);
         ready_before = in_ready;
         @(posedge clk);
         #1;
         if (!ready_before && model_drop < 255) model_drop++;
      end
      chk("sat_model", {24'd0, drop_cnt}, 32'(model_drop));
      chk("sat_255", {24'd0, drop_cnt}, 32'd255);
      repeat (40) @(posedge clk);
      #1;
      chk("sat_hold", {24'd0, drop_cnt}, 32'd255);
      in_valid = 1'b0;

      // Reset at E8 of a conversion of 1597.
      wait_ready();
      in_valid = 1'b1;
      in_data  = 16'd1597;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_bcd", {12'd0, bcd_out}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_dcnt", {29'd0, digit_count}, 32'd1);
      chk("mid_rst_drop", {24'd0, drop_cnt}, 32'd0);
      seen_pulse = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) seen_pulse++;
      end
      chk("mid_rst_no_pulse", 32'(seen_pulse), 32'd0);
      convert("fresh1597", 1597);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
